rf_write_arbiter: RTL



---
 rtl/rf_arb_pkg.sv | 28 ++
 rtl/rf_write_arbiter_if.sv | 16 +
 rtl/rf_hold_slot.sv | 36 +++
 rtl/rf_write_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: default widths,
// requester identifiers and the holding-slot record.
package rf_arb_pkg;

    localparam int RF_XLEN = 32;
    localparam int RF_AW   = 5;

    // Identifies a write source. This is also the encoding of the round-robin pointer.
    typedef enum logic {
        SRC_WB  = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    // One-entry holding slot. age=1 marks the younger of two same-cycle
    // residents, meaning the entry that must land last.
    typedef struct packed {
        logic               full;
        logic               age;
        logic [RF_AW-1:0]   addr;
        logic [RF_XLEN-1:0] data;
    } slot_t;

    // Returns the source that the pointer hands over to after it grants s.
    function automatic src_e src_other(input src_e s);
        return (s == SRC_WB) ? SRC_LSU : SRC_WB;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-request channel into the register-file write arbiter.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// While valid is high, the master holds addr and data stable. The slave
// derives ready from registered state only, so ready never depends on valid.
interface rf_write_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            valid;
    logic            ready;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/rf_hold_slot.sv
// One-entry holding register for a single write source. It loads on an
// accepted non-x0 request and clears when it is granted the write port,
// unless it reloads on that same edge. It also tracks its age relative
// to the sibling slot. Slot storage uses the widths from rf_arb_pkg.
module rf_hold_slot
    import rf_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,        // accepted request with addr != 0
    input  logic               drain,       // this slot is granted the write port
    input  logic               other_full,
    input  logic               other_drain,
    input  logic [RF_AW-1:0]   in_addr,
    input  logic [RF_XLEN-1:0] in_data,
    output slot_t              slot
);

    // Load, drain and age update for the slot.
    // A new entry is "younger" only when the sibling stays resident across this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load) begin
            slot.full <= 1'b1;
            slot.age  <= other_full && !other_drain;
            slot.addr <= in_addr;
            slot.data <= in_data;
        end else if (drain) begin
            slot <= '0;
        end else if (other_drain) begin
            slot.age <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the pipeline writeback
// (WB) and the load-return path (LSU). Each source has a one-entry slot.
// Occupied slots drain one per cycle. Arbitration is round-robin, and on
// a same-register conflict the older entry goes first.
// Optional feature macro: RF_WRITE_ARBITER_FWD_EN adds two read-forwarding ports.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_write_arbiter_if.slave    wb,
    rf_write_arbiter_if.slave    lsu,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_addr,
    output logic [XLEN-1:0]      rf_data,
    output logic [2**AW-1:0]     pend_mask
`ifdef RF_WRITE_ARBITER_FWD_EN
    ,
    input  logic [AW-1:0]        fwd_addr_a,
    input  logic [AW-1:0]        fwd_addr_b,
    output logic                 fwd_hit_a,
    output logic                 fwd_hit_b,
    output logic [XLEN-1:0]      fwd_data_a,
    output logic [XLEN-1:0]      fwd_data_b
`endif
);

    slot_t wb_s;
    slot_t lsu_s;
    src_e  rr_q;
    logic  gnt_wb;
    logic  gnt_lsu;
    logic  rr_step;
    logic  wb_load;
    logic  lsu_load;

    // A slot can take a new entry when it is empty or is draining this cycle.
    assign wb.ready  = !wb_s.full  || gnt_wb;
    assign lsu.ready = !lsu_s.full || gnt_lsu;

    // Writes to x0 complete the handshake but are never held.
    assign wb_load  = wb.valid  && wb.ready  && (wb.addr  != '0);
    assign lsu_load = lsu.valid && lsu.ready && (lsu.addr != '0);

    rf_hold_slot u_wb_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (wb_load),
        .drain       (gnt_wb),
        .other_full  (lsu_s.full),
        .other_drain (gnt_lsu),
        .in_addr     (wb.addr),
        .in_data     (wb.data),
        .slot        (wb_s)
    );

    rf_hold_slot u_lsu_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (lsu_load),
        .drain       (gnt_lsu),
        .other_full  (wb_s.full),
        .other_drain (gnt_wb),
        .in_addr     (lsu.addr),
        .in_data     (lsu.data),
        .slot        (lsu_s)
    );

    // Grant selection from registered slot state.
    // For the same register, the age=0 entry goes first and WB wins a tie.
    // For different registers, the round-robin pointer decides.
    always_comb begin
        gnt_wb  = 1'b0;
        gnt_lsu = 1'b0;
        rr_step = 1'b0;
        if (wb_s.full && lsu_s.full) begin
            if (wb_s.addr == lsu_s.addr) begin
                gnt_wb  = !wb_s.age;
                gnt_lsu = wb_s.age;
            end else begin
                rr_step = 1'b1;
                gnt_wb  = (rr_q == SRC_WB);
                gnt_lsu = (rr_q == SRC_LSU);
            end
        end else begin
            gnt_wb  = wb_s.full;
            gnt_lsu = lsu_s.full;
        end
    end

    // Round-robin pointer. It moves only on grants made by the pointer itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= SRC_WB;
        end else if (rr_step) begin
            rr_q <= src_other(rr_q);
        end
    end

    // Write-port mux. Outputs are held at zero when no slot is granted.
    always_comb begin
        rf_we   = gnt_wb || gnt_lsu;
        rf_addr = '0;
        rf_data = '0;
        if (gnt_wb) begin
            rf_addr = wb_s.addr;
            rf_data = wb_s.data;
        end else if (gnt_lsu) begin
            rf_addr = lsu_s.addr;
            rf_data = lsu_s.data;
        end
    end

    // Pending mask: one bit per held destination register. x0 is never pending.
    always_comb begin
        pend_mask = '0;
        if (wb_s.full)  pend_mask[wb_s.addr]  = 1'b1;
        if (lsu_s.full) pend_mask[lsu_s.addr] = 1'b1;
        pend_mask[0] = 1'b0;
    end

`ifdef RF_WRITE_ARBITER_FWD_EN
    // Forward lookup against both slots. On a double hit, the entry that
    // lands last wins: the age=1 slot, or LSU when both ages are zero.
    function automatic logic [XLEN:0] fwd_pick(input logic [AW-1:0] a,
                                               input slot_t w,
                                               input slot_t l);
        logic hw;
        logic hl;
        hw = w.full && (w.addr == a) && (a != '0);
        hl = l.full && (l.addr == a) && (a != '0);
        if (hw && (!hl || w.age)) return {1'b1, w.data};
        else if (hl)              return {1'b1, l.data};
        else                      return '0;
    endfunction

    assign {fwd_hit_a, fwd_data_a} = fwd_pick(fwd_addr_a, wb_s, lsu_s);
    assign {fwd_hit_b, fwd_data_b} = fwd_pick(fwd_addr_b, wb_s, lsu_s);
`endif

endmodule
